idreg_file: RTL
===============

// Module: idreg_file
//
// PURPOSE
//   Parametrised bank of NREG increment/decrement registers for the 2A03 datapath
//   (A, X, Y, S, PCL, PCH). One write-port operation per cycle (LOAD/INC/DEC),
//   two combinational read ports, registered Z/N/wrap flags, optional same-cycle
//   carry chaining of a register pair into a 2*WIDTH counter (PCL:PCH).
//
// PARAMETERS
//   WIDTH     8   bits per register
//   NREG      6   number of registers (>=2); SELW = clog2(NREG)
//   RST_VAL   0   reset value of every register except SP_IDX
//   SP_IDX    3   index of stack pointer; reset value SP_RST
//   SP_RST    8'hFD  stack pointer reset value (truncated to WIDTH)
//   CHAIN_EN  1   1 = regs CHAIN_LO and CHAIN_LO+1 form a chained counter
//   CHAIN_LO  4   low half of chained pair (CHAIN_LO+1 < NREG)
//   BYPASS    0   1 = read ports return the value being written this cycle
//
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active high
//   op_valid   in   1      operation strobe
//   op         in   2      0 NOP, 1 LOAD, 2 INC (+1), 3 DEC (-1)
//   wsel       in   SELW   target register index
//   din        in   WIDTH  LOAD data
//   rsel_a     in   SELW   read port A index
//   rdata_a    out  WIDTH  read port A data
//   rsel_b     in   SELW   read port B index
//   rdata_b    out  WIDTH  read port B data
//   flag_z     out  1      result of last executed op was zero
//   flag_n     out  1      MSB of last executed result
//   flag_wrap  out  1      last executed INC/DEC wrapped (max->0 or 0->max)
//   sel_err    out  1      one-cycle pulse: op_valid with wsel >= NREG
//
// BEHAVIOUR
// - Reset (rst=1 at edge): regs <= RST_VAL, reg[SP_IDX] <= SP_RST; flag_z,
//   flag_n, flag_wrap, sel_err <= 0. Reset overrides any op in the same cycle.
// - Executed op = op_valid & op!=NOP & wsel<NREG; result visible the next cycle.
// - LOAD: reg[wsel] <= din. INC/DEC: reg[wsel] <= reg[wsel] +/- 1 mod 2^WIDTH.
// - Chaining (CHAIN_EN=1, INC/DEC with wsel==CHAIN_LO): lo and hi update
//   together as one 2*WIDTH value {hi,lo} +/- 1 mod 2^(2*WIDTH), same cycle.
//   INC/DEC on hi alone, or any LOAD, touches only that register.
// - Flags on executed op: flag_z = (result==0), flag_n = result MSB; for a
//   chained INC/DEC result = {hi,lo} (Z over 2*WIDTH bits, N = hi MSB).
//   flag_wrap = 1 only if INC/DEC wrapped the full updated width
//   (chained: {hi,lo} FFFF->0000 or 0000->FFFF); LOAD clears it.
// - No executed op (op_valid=0, NOP, or bad wsel): all regs and flags hold.
// - sel_err: registered, 1 for exactly the cycle after op_valid & op!=NOP &
//   wsel>=NREG; else 0. Out-of-range rsel_x returns 0.
// - Reads: rdata_x = reg[rsel_x], combinational, zero latency.
//   BYPASS=0: returns pre-update value in the write cycle.
//   BYPASS=1: if an op executes to rsel_x this cycle, returns next-state
//   value (incl. chained hi updated by a CHAIN_LO op).
// - Both read ports may address the same or the write register freely.
//
// TESTING
// 1 Reset: rst=1 one cycle -> all regs 00, reg3=FD, all flags/sel_err 0.
// 2 LOAD r0=7F, INC r0 -> r0=80, N=1 Z=0 wrap=0; INC r0 x128 -> 00, Z=1 wrap=1.
// 3 DEC r3 from 00 -> FF, N=1 wrap=1; LOAD r3=05 -> wrap=0, flags Z=0 N=0.
// 4 Chain: r4=FF r5=12, INC r4 -> r4=00 r5=13 same cycle; r4=r5=FF, INC -> 0000,
//   Z=1 wrap=1; r4=r5=00, DEC r5 only -> r5=FF, r4=00.
// 5 BYPASS=1: LOAD r1=AA with rsel_a=1 -> rdata_a=AA same cycle; BYPASS=0 -> old.
// 6 wsel=7 INC -> no reg/flag change, sel_err=1 next cycle only; rst asserted
//   during INC r2 -> r2=00 next cycle.

Source files
------------

// File: rtl/idreg_file.sv
// Bank of increment/decrement registers with one write-port op per cycle, two
// combinational read ports, registered Z/N/wrap flags and an optional chained pair.
module idreg_file #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      NREG     = 6,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int unsigned      SP_IDX   = 3,
  parameter logic [WIDTH-1:0] SP_RST   = WIDTH'(8'hFD),
  parameter int unsigned      CHAIN_EN = 1,
  parameter int unsigned      CHAIN_LO = 4,
  parameter int unsigned      BYPASS   = 0,
  localparam int unsigned     SELW     = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [SELW-1:0]  wsel,
  input  logic [WIDTH-1:0] din,
  input  logic [SELW-1:0]  rsel_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [SELW-1:0]  rsel_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_wrap,
  output logic             sel_err
);

  localparam logic [1:0]      OP_NOP    = 2'd0;
  localparam logic [1:0]      OP_LOAD   = 2'd1;
  localparam logic [1:0]      OP_INC    = 2'd2;
  localparam logic [1:0]      OP_DEC    = 2'd3;
  localparam int unsigned     PAIRW     = 2 * WIDTH;
  localparam int unsigned     CHAIN_HI  = CHAIN_LO + 1;
  localparam logic [SELW:0]   NREG_W    = (SELW+1)'(NREG);
  localparam logic [SELW-1:0] CHAIN_SEL = SELW'(CHAIN_LO);

  logic [WIDTH-1:0] regs     [NREG];
  logic [WIDTH-1:0] regs_nxt [NREG];

  logic             active;
  logic             exec;
  logic             is_step;
  logic             is_inc;
  logic             chain_op;
  logic [WIDTH-1:0] cur_w;
  logic [WIDTH-1:0] res;
  logic [PAIRW-1:0] pair;
  logic [PAIRW-1:0] pair_res;
  logic             res_z;
  logic             res_n;
  logic             res_wrap;

  // Decode the write-port operation and compute its result and flags.
  always_comb begin
    active   = op_valid && (op != OP_NOP);
    exec     = active && ({1'b0, wsel} < NREG_W);
    is_step  = (op == OP_INC) || (op == OP_DEC);
    is_inc   = (op == OP_INC);
    chain_op = (CHAIN_EN != 0) && is_step && (wsel == CHAIN_SEL);

    cur_w = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (wsel == SELW'(i)) cur_w = regs[i];
    end

    pair     = {regs[CHAIN_HI], regs[CHAIN_LO]};
    pair_res = is_inc ? pair + PAIRW'(1) : pair - PAIRW'(1);

    if (op == OP_LOAD) res = din;
    else               res = is_inc ? cur_w + WIDTH'(1) : cur_w - WIDTH'(1);

    res_z    = chain_op ? (pair_res == '0) : (res == '0);
    res_n    = chain_op ? pair_res[PAIRW-1] : res[WIDTH-1];
    res_wrap = 1'b0;
    if (is_step) begin
      if (chain_op) res_wrap = is_inc ? (&pair) : (pair == '0);
      else          res_wrap = is_inc ? (&cur_w) : (cur_w == '0);
    end
  end

  // Next-state register bank; the chained hi half follows a CHAIN_LO step.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      regs_nxt[i] = regs[i];
      if (exec && (wsel == SELW'(i))) begin
        regs_nxt[i] = chain_op ? pair_res[WIDTH-1:0] : res;
      end
      if (exec && chain_op && (i == int'(CHAIN_HI))) begin
        regs_nxt[i] = pair_res[PAIRW-1:WIDTH];
      end
    end
  end

  // Read ports; bypass variant exposes the value being written this cycle.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rsel_a == SELW'(i)) rdata_a = (BYPASS != 0) ? regs_nxt[i] : regs[i];
      if (rsel_b == SELW'(i)) rdata_b = (BYPASS != 0) ? regs_nxt[i] : regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RST : RST_VAL;
      end
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      regs    <= regs_nxt;
      sel_err <= active && !exec;
      if (exec) begin
        flag_z    <= res_z;
        flag_n    <= res_n;
        flag_wrap <= res_wrap;
      end
    end
  end

endmodule
